// File: rtl/pong_pkg.sv
// Shared constants for the pong button path: channel count, button
// indices and default timing for the button conditioner.
package pong_pkg;

  localparam int NUM_BTN = 6;

  localparam int BTN_P1_LEFT   = 0;
  localparam int BTN_P1_RIGHT  = 1;
  localparam int BTN_P1_SELECT = 2;
  localparam int BTN_P2_LEFT   = 3;
  localparam int BTN_P2_RIGHT  = 4;
  localparam int BTN_P2_SELECT = 5;

  // 1 ms sample tick at the 25.175 MHz pixel clock.
  localparam int DEFAULT_PRESCALE       = 25175;
  localparam int DEFAULT_DEBOUNCE_TICKS = 10;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: optional inversion, two-flop synchroniser,
// tick-based debounce counter, stable level and press/release pulses.
module btn_debounce_channel #(
  parameter int ACTIVE_LOW     = 0,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic tick_i,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             raw;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Next-state: synchroniser always samples; debounce only advances while enabled.
  always_comb begin
    raw       = (ACTIVE_LOW != 0) ? ~pin_i : pin_i;
    sync1_d   = raw;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (en_i) begin
      if (sync2_q == stable_q) begin
        // Any agreeing cycle throws away a partial debounce run.
        cnt_d = '0;
      end else if (tick_i) begin
        if (cnt_q == CNT_LAST) begin
          stable_d  = ~stable_q;
          cnt_d     = '0;
          press_d   = ~stable_q;
          release_d = stable_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous reset to the released state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner: one shared sample-tick prescaler feeding NUM_BTN
// independent debounce channels. Outputs are clean, synchronous to clk.
module btn_conditioner #(
  parameter int NUM_BTN        = pong_pkg::NUM_BTN,
  parameter int PRESCALE       = pong_pkg::DEFAULT_PRESCALE,
  parameter int DEBOUNCE_TICKS = pong_pkg::DEFAULT_DEBOUNCE_TICKS,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_pin,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  import pong_pkg::*;

  localparam int PRE_W = idx_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  // Prescaler next-state: counts only while enabled, wraps at PRESCALE-1.
  always_comb begin
    tick  = en && (pre_q == PRE_LAST);
    pre_d = pre_q;
    if (en) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .tick_i    (tick),
      .pin_i     (btn_pin[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with small timing (PRESCALE=4, DEBOUNCE_TICKS=3).
// A second instance with inverted pin polarity receives the complement of
// the same pins, so both must match one reference model.
module tb_btn_conditioner;

  localparam int NB = 6;
  localparam int P  = 4;
  localparam int DT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NB-1:0] pin;
  logic [NB-1:0] pin_n;
  logic [NB-1:0] level, press, rel;
  logic [NB-1:0] al_level, al_press, al_rel;

  int total = 0;
  int bad   = 0;

  assign pin_n = ~pin;

  btn_conditioner #(.NUM_BTN(NB), .PRESCALE(P), .DEBOUNCE_TICKS(DT), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .en(en), .btn_pin(pin),
    .btn_level(level), .btn_press(press), .btn_release(rel)
  );

  btn_conditioner #(.NUM_BTN(NB), .PRESCALE(P), .DEBOUNCE_TICKS(DT), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .btn_pin(pin_n),
    .btn_level(al_level), .btn_press(al_press), .btn_release(al_rel)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The pressed-sense pin is seen two clocks late. A sample tick falls on
  // every PRESCALE-th enabled cycle since reset. A level flips once the
  // delayed pin has disagreed with it across DT ticks with no agreeing
  // enabled cycle in between; the flip produces a one-cycle pulse.
  logic [NB-1:0] m_d1 = '0, m_d2 = '0;
  logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0;
  int            m_en_cycles = 0;
  int            m_ticks_seen [NB];
  bit            m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0;
      m_level = '0; m_press = '0; m_rel = '0;
      m_en_cycles = 0;
      for (int c = 0; c < NB; c++) m_ticks_seen[c] = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      if (en) begin
        m_tick = ((m_en_cycles % P) == P - 1);
        m_en_cycles++;
        for (int c = 0; c < NB; c++) begin
          if (m_d2[c] == m_level[c]) begin
            m_ticks_seen[c] = 0;
          end else if (m_tick) begin
            m_ticks_seen[c]++;
            if (m_ticks_seen[c] == DT) begin
              m_level[c] = ~m_level[c];
              m_ticks_seen[c] = 0;
              if (m_level[c]) m_press[c] = 1'b1;
              else            m_rel[c]   = 1'b1;
            end
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = pin;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int n, input int lo, input int hi);
    total++;
    if (n < lo || n > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, n, lo, hi);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("level",       32'(level),    32'(m_level));
    check("press",       32'(press),    32'(m_press));
    check("release",     32'(rel),      32'(m_rel));
    check("al_level",    32'(al_level), 32'(m_level));
    check("al_press",    32'(al_press), 32'(m_press));
    check("al_release",  32'(al_rel),   32'(m_rel));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until level[ch]==val, optionally dropping en for gap_len
  // edges starting after edge gap_at. Returns at the negedge of the change.
  task automatic measure(input int ch, input logic val, input int gap_at,
                         input int gap_len, output int n);
    n = 0;
    while (n < 80) begin
      @(posedge clk);
      n++;
      #1;
      if (gap_at >= 0) begin
        if (n == gap_at)           en = 1'b0;
        if (n == gap_at + gap_len) en = 1'b1;
      end
      @(negedge clk);
      if (level[ch] == val) break;
    end
  endtask

  // Checks the pulse at the current negedge and its clearing one cycle later.
  task automatic check_pulse(input string name, input int ch, input logic is_press);
    check({name, "_on"},  32'({press[ch], rel[ch]}), is_press ? 32'd2 : 32'd1);
    @(negedge clk);
    check({name, "_off"}, 32'({press[ch], rel[ch]}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    en  = 1'b1;
    pin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Inverted-polarity instance sees all pins high: nothing may happen.
    repeat (100) begin
      @(negedge clk);
      check("al_idle", 32'({al_level, al_press, al_rel}), 32'd0);
    end

    // Clean press on channel 0.
    step();
    pin[0] = 1'b1;
    measure(0, 1'b1, -1, 0, n);
    check_range("press_latency", n, 11, 14);
    check("press_others", 32'(level[NB-1:1]), 32'd0);
    check_pulse("press_pulse", 0, 1'b1);
    repeat (10) step();
    check("press_held", 32'({level[0], press[0]}), 32'd2);

    // Five-cycle glitch on channel 1.
    pin[1] = 1'b1;
    repeat (5) step();
    pin[1] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      check("glitch", 32'({level[1], press[1], rel[1]}), 32'd0);
    end

    // Release of channel 0.
    step();
    pin[0] = 1'b0;
    measure(0, 1'b0, -1, 0, n);
    check_range("release_latency", n, 11, 14);
    check_pulse("release_pulse", 0, 1'b0);
    repeat (10) step();

    // Press with a 20-cycle enable gap in the middle.
    pin[0] = 1'b1;
    measure(0, 1'b1, 3, 20, n);
    check_range("en_gap_latency", n, 31, 34);
    check_pulse("en_gap_pulse", 0, 1'b1);
    repeat (5) step();
    pin[0] = 1'b0;
    measure(0, 1'b0, -1, 0, n);
    check_range("release2_latency", n, 11, 14);
    repeat (10) step();

    // Reset six cycles into a press debounce.
    pin[0] = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_clear", 32'({level, press, rel}), 32'd0);
    measure(0, 1'b1, -1, 0, n);
    check_range("post_rst_latency", n, 11, 14);
    check_pulse("post_rst_pulse", 0, 1'b1);

    // Randomised traffic: bouncing pins, enable drops, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 19) == 0) pin[c] = ~pin[c];
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 399) == 0);
    end
    step();
    rst = 1'b0;
    en  = 1'b1;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 6, number of button channels (P1 left/right/select, P2 left/right/select).
REQ-002 Parameter PRESCALE, default 25175, clk cycles per sample tick (1 ms at 25.175 MHz).
REQ-003 Parameter DEBOUNCE_TICKS, default 10, consecutive mismatching ticks required to accept a new level; legal range 1..255.
REQ-004 Parameter ACTIVE_LOW, default 0; when 1 each raw pin is inverted before synchronisation.
REQ-005 clk  input  1  single system clock (VGA pixel clock domain); no other clock exists.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 en  input  1  global enable, same meaning as the game core enable.
REQ-008 btn_pin  input  NUM_BTN  raw asynchronous board button/switch levels.
REQ-009 btn_level  output  NUM_BTN  debounced level, 1 = pressed.
REQ-010 btn_press  output  NUM_BTN  one-cycle pulse on accepted 0->1 transition.
REQ-011 btn_release  output  NUM_BTN  one-cycle pulse on accepted 1->0 transition.

Function
REQ-012 Each bit passes through a two-flop synchroniser after optional inversion; no logic reads the first flop.
REQ-013 One shared prescaler counts 0..PRESCALE-1 while en=1, wraps to 0, asserts an internal tick for the single cycle its count equals PRESCALE-1.
REQ-014 en=0: prescaler holds its count, tick=0, debounce counters and btn_level hold, btn_press/btn_release=0; synchronisers keep sampling.
REQ-015 Per channel: registered stable bit (drives btn_level) and tick counter of width clog2(DEBOUNCE_TICKS+1).
REQ-016 Any cycle where synchronised value equals stable: counter cleared to 0 that edge, independent of tick.
REQ-017 Synchronised value differs from stable and tick=1: counter increments; if counter already equals DEBOUNCE_TICKS-1, stable toggles and counter clears instead.
REQ-018 Synchronised value differs, tick=0: counter holds.
REQ-019 btn_press/btn_release are registered, asserted on the same edge stable toggles, cleared the next edge; never both high on one channel; never high for two consecutive cycles.
REQ-020 Pin-to-level latency for a clean edge: between 2+(DEBOUNCE_TICKS-1)*PRESCALE+1 and 2+DEBOUNCE_TICKS*PRESCALE cycles.
REQ-021 Any pulse or bounce shorter than (DEBOUNCE_TICKS-1)*PRESCALE+1 cycles leaves btn_level, btn_press, btn_release unchanged.
REQ-022 Channels independent; simultaneous transitions on several channels produce simultaneous pulses.
REQ-023 Counter never exceeds DEBOUNCE_TICKS-1; no wrap-around.

Reset
REQ-024 While rst=1 at a clock edge: synchroniser flops, stable bits, counters, prescaler count, btn_level, btn_press, btn_release all set to 0 (released).
REQ-025 rst has priority over en and over any pending toggle; a reset mid-debounce discards partial count and emits no pulse.
REQ-026 A button held through reset is treated as a new press after reset: full debounce, then one btn_press pulse.

Structure
REQ-027 Shared package pong_pkg holds NUM_BTN, button index constants (BTN_P1_LEFT=0, BTN_P1_RIGHT=1, BTN_P1_SELECT=2, BTN_P2_LEFT=3, BTN_P2_RIGHT=4, BTN_P2_SELECT=5) and default PRESCALE/DEBOUNCE_TICKS.
REQ-028 Sub-module btn_debounce_channel (synchroniser, counter, stable bit, pulse regs) instantiated NUM_BTN times; prescaler lives in btn_conditioner.
REQ-029 Outputs feed the game core button inputs directly; game core needs no further synchronisation.

Verification (PRESCALE=4, DEBOUNCE_TICKS=3, ACTIVE_LOW=0)
REQ-030 Clean press: btn_pin[0] 0->1 held -> btn_level[0] rises 11..14 cycles later, btn_press[0] high exactly 1 cycle at that edge, other channels 0.
REQ-031 Glitch: btn_pin[1] high 5 cycles then low -> btn_level, btn_press, btn_release stay 0 throughout.
REQ-032 Release: after accepted press, btn_pin[0] 1->0 -> btn_level[0] falls 11..14 cycles later with one-cycle btn_release[0].
REQ-033 en gating: en=0 for 20 cycles during a press debounce -> level unchanged during gap, latency extended by exactly 20 cycles.
REQ-034 Reset mid-debounce: rst=1 one cycle 6 cycles after pin rise, pin held high -> no pulse, all outputs 0 next cycle, press accepted 11..14 cycles after rst low.
REQ-035 ACTIVE_LOW=1, all pins held 1 from reset -> all btn_level stay 0, no pulses for 100 cycles.
